// File: rtl/alu_long_sequencer.sv
// Drives a WIDTH-bit Alu one half per cycle to run word or long operations.
// The carry is chained through the Alu X input. The block assembles a 2*WIDTH result and CCR flags.
module alu_long_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic                 size,
    input  logic                 x_in,
    input  logic [2*WIDTH-1:0]   a,
    input  logic [2*WIDTH-1:0]   b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 flag_x,
    output logic                 flag_n,
    output logic                 flag_z,
    output logic                 flag_v,
    output logic                 flag_c,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [2:0]           alu_op,
    output logic                 alu_x,
    input  logic [WIDTH-1:0]     alu_o,
    input  logic                 alu_c,
    input  logic                 alu_z,
    input  logic                 alu_v,
    input  logic                 alu_n
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t               state_reg, state_next;
    logic [2:0]           op_reg;
    logic                 size_reg;
    logic                 x_reg;
    logic [2*WIDTH-1:0]   a_reg, b_reg;
    logic [WIDTH-1:0]     lo_reg;
    logic                 z_lo_reg, c_lo_reg;
    logic [2*WIDTH-1:0]   result_reg, result_next;
    logic                 fx_reg, fn_reg, fz_reg, fv_reg, fc_reg;
    logic                 fx_next, fz_next, fv_next, fc_next;
    logic                 is_arith;
    logic                 accept;
    logic                 finish;

    assign is_arith = (op_reg == OP_ADD) || (op_reg == OP_SUB);
    assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign finish   = ((state_reg == LO) && !size_reg) || (state_reg == HI);

    always_comb begin
        state_next = state_reg;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = 3'b000;
        alu_x      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = LO;
            end
            LO: begin
                alu_a      = a_reg[WIDTH-1:0];
                alu_b      = b_reg[WIDTH-1:0];
                alu_op     = op_reg;
                alu_x      = is_arith & x_reg;
                state_next = size_reg ? HI : DONE;
            end
            HI: begin
                alu_a      = a_reg[2*WIDTH-1:WIDTH];
                alu_b      = b_reg[2*WIDTH-1:WIDTH];
                alu_op     = op_reg;
                alu_x      = is_arith & c_lo_reg;
                state_next = DONE;
            end
            DONE: begin
                state_next = start ? LO : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Word ops keep the upper operand half; long ops need Z over both halves.
    always_comb begin
        result_next = {a_reg[2*WIDTH-1:WIDTH], alu_o};
        fz_next     = alu_z;
        if (state_reg == HI) begin
            result_next = {alu_o, lo_reg};
            fz_next     = z_lo_reg & alu_z;
        end
        fc_next = is_arith & alu_c;
        fv_next = is_arith & alu_v;
        fx_next = is_arith ? alu_c : x_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            op_reg     <= 3'b000;
            size_reg   <= 1'b0;
            x_reg      <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            lo_reg     <= '0;
            z_lo_reg   <= 1'b0;
            c_lo_reg   <= 1'b0;
            result_reg <= '0;
            fx_reg     <= 1'b0;
            fn_reg     <= 1'b0;
            fz_reg     <= 1'b0;
            fv_reg     <= 1'b0;
            fc_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg   <= op;
                size_reg <= size;
                x_reg    <= x_in;
                a_reg    <= a;
                b_reg    <= b;
            end
            if (state_reg == LO) begin
                lo_reg   <= alu_o;
                z_lo_reg <= alu_z;
                c_lo_reg <= alu_c;
            end
            if (finish) begin
                result_reg <= result_next;
                fx_reg     <= fx_next;
                fn_reg     <= alu_n;
                fz_reg     <= fz_next;
                fv_reg     <= fv_next;
                fc_reg     <= fc_next;
            end
        end
    end

    assign busy   = (state_reg == LO) || (state_reg == HI);
    assign done   = (state_reg == DONE);
    assign result = result_reg;
    assign flag_x = fx_reg;
    assign flag_n = fn_reg;
    assign flag_z = fz_reg;
    assign flag_v = fv_reg;
    assign flag_c = fc_reg;

endmodule

// File: tb/tb_alu_long_sequencer.sv
// Directed bench for alu_long_sequencer with an attached 16-bit Alu model.
// A whole-operand reference scoreboard is checked every cycle.
module tb_alu_long_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic        size = 1'b0;
    logic        x_in = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] result;
    logic        flag_x, flag_n, flag_z, flag_v, flag_c;
    logic [15:0] alu_a, alu_b, alu_o;
    logic [2:0]  alu_op;
    logic        alu_x, alu_c, alu_z, alu_v, alu_n;

    int checks = 0;
    int passes = 0;
    logic last_hi_x;

    alu_long_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .size(size), .x_in(x_in),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .flag_x(flag_x), .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_x(alu_x),
        .alu_o(alu_o), .alu_c(alu_c), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n)
    );

    always #5 clk = ~clk;

    // 16-bit Alu: ADD/SUB with X as carry/borrow in, logic ops, pass A.
    logic [16:0] alu_s;
    always_comb begin
        alu_s = '0;
        alu_o = alu_a;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_op)
            3'b000: begin
                alu_s = {1'b0, alu_a} + {1'b0, alu_b} + {16'b0, alu_x};
                alu_o = alu_s[15:0];
                alu_c = alu_s[16];
                alu_v = (alu_a[15] == alu_b[15]) && (alu_o[15] != alu_a[15]);
            end
            3'b001: begin
                alu_s = {1'b0, alu_a} - {1'b0, alu_b} - {16'b0, alu_x};
                alu_o = alu_s[15:0];
                alu_c = alu_s[16];
                alu_v = (alu_a[15] != alu_b[15]) && (alu_o[15] != alu_a[15]);
            end
            3'b010: alu_o = alu_a & alu_b;
            3'b011: alu_o = alu_a | alu_b;
            3'b100: alu_o = alu_a ^ alu_b;
            default: alu_o = alu_a;
        endcase
        alu_n = alu_o[15];
        alu_z = (alu_o == 16'h0000);
    end

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  fl;   // {x,n,z,v,c}
    } ref_t;

    // Whole-operand reference: plain 32-bit or 16-bit arithmetic, no halves.
    function automatic ref_t ref_op(input logic [2:0] o, input logic sz, input logic xi,
                                    input logic [31:0] aa, input logic [31:0] bb);
        ref_t r;
        logic [32:0] s;
        logic [16:0] s16;
        logic [15:0] w;
        logic [31:0] res;
        logic c, v, n, z;
        c = 1'b0; v = 1'b0; s = '0; s16 = '0; w = '0; res = '0;
        if (sz) begin
            case (o)
                3'b000: begin
                    s = {1'b0, aa} + {1'b0, bb} + {32'b0, xi};
                    res = s[31:0]; c = s[32];
                    v = (aa[31] == bb[31]) && (res[31] != aa[31]);
                end
                3'b001: begin
                    s = {1'b0, aa} - {1'b0, bb} - {32'b0, xi};
                    res = s[31:0]; c = s[32];
                    v = (aa[31] != bb[31]) && (res[31] != aa[31]);
                end
                3'b010: res = aa & bb;
                3'b011: res = aa | bb;
                3'b100: res = aa ^ bb;
                default: res = aa;
            endcase
            n = res[31];
            z = (res == 32'h0);
        end else begin
            case (o)
                3'b000: begin
                    s16 = {1'b0, aa[15:0]} + {1'b0, bb[15:0]} + {16'b0, xi};
                    w = s16[15:0]; c = s16[16];
                    v = (aa[15] == bb[15]) && (w[15] != aa[15]);
                end
                3'b001: begin
                    s16 = {1'b0, aa[15:0]} - {1'b0, bb[15:0]} - {16'b0, xi};
                    w = s16[15:0]; c = s16[16];
                    v = (aa[15] != bb[15]) && (w[15] != aa[15]);
                end
                3'b010: w = aa[15:0] & bb[15:0];
                3'b011: w = aa[15:0] | bb[15:0];
                3'b100: w = aa[15:0] ^ bb[15:0];
                default: w = aa[15:0];
            endcase
            res = {aa[31:16], w};
            n = w[15];
            z = (w == 16'h0);
        end
        r.res = res;
        r.fl  = {((o == 3'b000) || (o == 3'b001)) ? c : xi, n, z, v, c};
        return r;
    endfunction

    // Scoreboard: cycles remaining until done, plus the held result/flags.
    int          m_cnt;
    logic        m_done;
    logic [31:0] m_res;
    logic [4:0]  m_fl;
    ref_t        m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_fl   <= '0;
            m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    m_res  <= m_pend.res;
                    m_fl   <= m_pend.fl;
                end
            end else if (start) begin
                m_pend <= ref_op(op, size, x_in, a, b);
                m_cnt  <= size ? 2 : 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("cyc busy", {31'b0, busy}, {31'b0, (m_cnt > 0)});
        chk("cyc done", {31'b0, done}, {31'b0, m_done});
        chk("cyc result", result, m_res);
        chk("cyc flags", {27'b0, flag_x, flag_n, flag_z, flag_v, flag_c}, {27'b0, m_fl});
    end

    task automatic run_op(input string nm, input logic [2:0] o, input logic sz, input logic xi,
                          input logic [31:0] aa, input logic [31:0] bb,
                          input logic [31:0] er, input logic [4:0] ef, input int el);
        int lat;
        int busy_n;
        logic hx;
        @(negedge clk);
        start = 1'b1; op = o; size = sz; x_in = xi; a = aa; b = bb;
        @(negedge clk);
        start = 1'b0;
        lat = 1; busy_n = 0; hx = 1'b0;
        while (!done && lat < 10) begin
            if (busy) busy_n++;
            if (lat == 2) hx = alu_x;
            @(negedge clk);
            lat++;
        end
        last_hi_x = hx;
        chk({nm, " done"}, {31'b0, done}, 32'd1);
        chk({nm, " latency"}, lat, el);
        chk({nm, " busy cycles"}, busy_n, el - 1);
        chk({nm, " result"}, result, er);
        chk({nm, " flags xnzvc"}, {27'b0, flag_x, flag_n, flag_z, flag_v, flag_c}, {27'b0, ef});
        $display("%s: a=%h b=%h x=%0d -> result=%h xnzvc=%b latency=%0d",
                 nm, aa, bb, xi, result, {flag_x, flag_n, flag_z, flag_v, flag_c}, lat);
    endtask

    initial begin
        int dn;
        #2 rst_n = 1'b0;
        #1;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset flags", {27'b0, flag_x, flag_n, flag_z, flag_v, flag_c}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("long ADD carry", 3'b000, 1'b1, 1'b0, 32'h0000FFFF, 32'h00000001, 32'h00010000, 5'b00000, 3);
        run_op("long SUB borrow", 3'b001, 1'b1, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 5'b11001, 3);
        chk("long SUB alu_x in HI", {31'b0, last_hi_x}, 32'd1);
        run_op("long AND nonzero", 3'b010, 1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00010000, 5'b00000, 3);
        run_op("long AND zero", 3'b010, 1'b1, 1'b1, 32'h00010000, 32'h00000001, 32'h00000000, 5'b10100, 3);
        run_op("word ADD overflow", 3'b000, 1'b0, 1'b0, 32'hABCD7FFF, 32'h12340001, 32'hABCD8000, 5'b01010, 2);
        run_op("long ADD x wrap", 3'b000, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 5'b10101, 3);
        run_op("word SUB with x", 3'b001, 1'b0, 1'b1, 32'h55550005, 32'h00000003, 32'h55550001, 5'b00000, 2);
        run_op("long pass A", 3'b101, 1'b1, 1'b1, 32'h80000000, 32'h12345678, 32'h80000000, 5'b11000, 3);

        // Start held high while busy is ignored; a start during DONE launches the next op.
        @(negedge clk);
        start = 1'b1; op = 3'b011; size = 1'b1; x_in = 1'b1; a = 32'h12340000; b = 32'h00005678;
        @(negedge clk);
        op = 3'b000; size = 1'b0; x_in = 1'b0; a = 32'h1; b = 32'h1;
        chk("b2b busy LO", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("b2b busy HI", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("b2b OR done", {31'b0, done}, 32'd1);
        chk("b2b OR result", result, 32'h12345678);
        chk("b2b OR flags", {27'b0, flag_x, flag_n, flag_z, flag_v, flag_c}, 32'b10000);
        $display("long OR: result=%h xnzvc=%b", result, {flag_x, flag_n, flag_z, flag_v, flag_c});
        op = 3'b100; size = 1'b0; x_in = 1'b0; a = 32'hBEEFFFFF; b = 32'h0000FFFF;
        @(negedge clk);
        start = 1'b0;
        chk("b2b XOR busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("b2b XOR done", {31'b0, done}, 32'd1);
        chk("b2b XOR result", result, 32'hBEEF0000);
        chk("b2b XOR flags", {27'b0, flag_x, flag_n, flag_z, flag_v, flag_c}, 32'b00100);
        $display("word XOR back-to-back: result=%h xnzvc=%b", result, {flag_x, flag_n, flag_z, flag_v, flag_c});

        // Reset during the HI half of a long op.
        @(negedge clk);
        start = 1'b1; op = 3'b000; size = 1'b1; x_in = 1'b0; a = 32'h00010001; b = 32'h00000001;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 chk("abort in HI busy", {31'b0, busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort done", {31'b0, done}, 32'd0);
        chk("abort result", result, 32'd0);
        chk("abort flags", {27'b0, flag_x, flag_n, flag_z, flag_v, flag_c}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort no done", dn, 0);
        $display("reset abort: done pulses after release=%0d", dn);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
